// File: rtl/fu_result_arbiter.sv
// Functional-unit result arbiter: per-FU FIFOs feeding one writeback port through a
// round-robin arbiter with valid/ready handshakes and a synchronous flush.
module fu_result_arbiter #(
    parameter int unsigned NUM_FU       = 4,
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned INST_ID_BITS = 6,
    parameter int unsigned PRN_BITS     = 6,
    parameter int unsigned MAX_OPERANDS = 3,
    parameter int unsigned SRC_BITS     = $clog2(NUM_FU)
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic                                                flush,
    input  logic [NUM_FU-1:0]                                   fu_out_valid,
    output logic [NUM_FU-1:0]                                   fu_out_ready,
    input  logic [NUM_FU-1:0][INST_ID_BITS-1:0]                 fu_out_inst_id,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]   fu_out_prn,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0][63:0]           fu_out_data,
    input  logic [NUM_FU-1:0][MAX_OPERANDS-1:0]                 fu_out_data_valid,
    output logic                                                wb_valid,
    input  logic                                                wb_ready,
    output logic [INST_ID_BITS-1:0]                             wb_inst_id,
    output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]               wb_prn,
    output logic [MAX_OPERANDS-1:0][63:0]                       wb_data,
    output logic [MAX_OPERANDS-1:0]                             wb_data_valid,
    output logic [SRC_BITS-1:0]                                 wb_src
);

    localparam int unsigned PtrBits = $clog2(FIFO_DEPTH);
    localparam int unsigned CntBits = $clog2(FIFO_DEPTH + 1);

    // Packet storage (not reset: contents are only observed when count says valid)
    logic [INST_ID_BITS-1:0]                   mem_inst_id [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]     mem_prn     [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0][63:0]             mem_data    [NUM_FU][FIFO_DEPTH];
    logic [MAX_OPERANDS-1:0]                   mem_dv      [NUM_FU][FIFO_DEPTH];

    logic [PtrBits-1:0]  head_q  [NUM_FU];
    logic [PtrBits-1:0]  tail_q  [NUM_FU];
    logic [CntBits-1:0]  count_q [NUM_FU];

    logic [SRC_BITS-1:0] rr_ptr_q;
    logic [SRC_BITS-1:0] sel_q;
    logic                lock_q;

    logic [NUM_FU-1:0]   nonempty;
    logic [NUM_FU-1:0]   push;
    logic [NUM_FU-1:0]   pop;
    logic [SRC_BITS-1:0] scan_sel;
    logic [SRC_BITS-1:0] sel;
    logic                found;
    logic                accept;
    logic [SRC_BITS-1:0] rr_next;

    // Channel status, handshakes and push/pop decode; flush suppresses both
    always_comb begin
        for (int i = 0; i < NUM_FU; i++) begin
            nonempty[i]     = (count_q[i] != '0);
            fu_out_ready[i] = !rst && (count_q[i] != CntBits'(FIFO_DEPTH));
        end
        push   = fu_out_valid & fu_out_ready & {NUM_FU{!flush}};
        accept = wb_valid && wb_ready && !flush;
        for (int i = 0; i < NUM_FU; i++) begin
            pop[i] = accept && (sel == SRC_BITS'(i));
        end
    end

    // Round-robin scan starting at rr_ptr; a locked grant overrides the scan
    always_comb begin
        found    = 1'b0;
        scan_sel = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            if (!found && nonempty[(int'(rr_ptr_q) + k) % NUM_FU]) begin
                scan_sel = SRC_BITS'((int'(rr_ptr_q) + k) % NUM_FU);
                found    = 1'b1;
            end
        end
        sel      = lock_q ? sel_q : scan_sel;
        wb_valid = |nonempty;
        rr_next  = (sel == SRC_BITS'(NUM_FU - 1)) ? '0 : sel + SRC_BITS'(1);
    end

    // Writeback payload: head of the granted channel, zero when nothing is valid
    always_comb begin
        wb_inst_id    = '0;
        wb_prn        = '0;
        wb_data       = '0;
        wb_data_valid = '0;
        wb_src        = '0;
        if (wb_valid) begin
            wb_inst_id    = mem_inst_id[sel][head_q[sel]];
            wb_prn        = mem_prn[sel][head_q[sel]];
            wb_data       = mem_data[sel][head_q[sel]];
            wb_data_valid = mem_dv[sel][head_q[sel]];
            wb_src        = sel;
        end
    end

    // FIFO pointers and occupancy per channel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < NUM_FU; i++) begin
                head_q[i]  <= '0;
                tail_q[i]  <= '0;
                count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (push[i]) tail_q[i] <= tail_q[i] + PtrBits'(1);
                if (pop[i])  head_q[i] <= head_q[i] + PtrBits'(1);
                if (push[i] && !pop[i])      count_q[i] <= count_q[i] + CntBits'(1);
                else if (pop[i] && !push[i]) count_q[i] <= count_q[i] - CntBits'(1);
            end
        end
    end

    // Packet write at the tail of each accepting channel
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (push[i]) begin
                mem_inst_id[i][tail_q[i]] <= fu_out_inst_id[i];
                mem_prn[i][tail_q[i]]     <= fu_out_prn[i];
                mem_data[i][tail_q[i]]    <= fu_out_data[i];
                mem_dv[i][tail_q[i]]      <= fu_out_data_valid[i];
            end
        end
    end

    // Grant lock holds a stalled selection stable; acceptance advances rr_ptr
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            sel_q    <= '0;
            lock_q   <= 1'b0;
        end else if (flush) begin
            lock_q <= 1'b0;
        end else if (accept) begin
            lock_q   <= 1'b0;
            rr_ptr_q <= rr_next;
        end else if (wb_valid) begin
            lock_q <= 1'b1;
            sel_q  <= sel;
        end
    end

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Directed bench for fu_result_arbiter: ordering, backpressure, lock, flush and reset.
module tb_fu_result_arbiter;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    flush;
    logic [3:0]              fu_out_valid;
    logic [3:0]              fu_out_ready;
    logic [3:0][5:0]         fu_out_inst_id;
    logic [3:0][2:0][5:0]    fu_out_prn;
    logic [3:0][2:0][63:0]   fu_out_data;
    logic [3:0][2:0]         fu_out_data_valid;
    logic                    wb_valid;
    logic                    wb_ready;
    logic [5:0]              wb_inst_id;
    logic [2:0][5:0]         wb_prn;
    logic [2:0][63:0]        wb_data;
    logic [2:0]              wb_data_valid;
    logic [1:0]              wb_src;

    int total = 0;
    int fails = 0;

    fu_result_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .fu_out_valid      (fu_out_valid),
        .fu_out_ready      (fu_out_ready),
        .fu_out_inst_id    (fu_out_inst_id),
        .fu_out_prn        (fu_out_prn),
        .fu_out_data       (fu_out_data),
        .fu_out_data_valid (fu_out_data_valid),
        .wb_valid          (wb_valid),
        .wb_ready          (wb_ready),
        .wb_inst_id        (wb_inst_id),
        .wb_prn            (wb_prn),
        .wb_data           (wb_data),
        .wb_data_valid     (wb_data_valid),
        .wb_src            (wb_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        fu_out_valid      = '0;
        fu_out_inst_id    = '0;
        fu_out_prn        = '0;
        fu_out_data       = '0;
        fu_out_data_valid = '0;
    endtask

    task automatic drive(input int fu, input logic [5:0] id, input logic [5:0] p0,
                         input logic [63:0] d0, input logic [2:0] dv);
        fu_out_valid[fu]         = 1'b1;
        fu_out_inst_id[fu]       = id;
        fu_out_prn[fu]           = '0;
        fu_out_prn[fu][0]        = p0;
        fu_out_data[fu]          = '0;
        fu_out_data[fu][0]       = d0;
        fu_out_data_valid[fu]    = dv;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wb_ready = 1'b0;
        clear_in();
        #2;
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_ready", fu_out_ready, 0);
        chk("rst_src", wb_src, 0);
        chk("rst_data", wb_data[0], 0);
        chk("rst_rr", dut.rr_ptr_q, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready", fu_out_ready, 4'hF);

        // Round-robin: all FUs push together, grants 0..3
        wb_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 6'h20 + 6'(i), 6'(i), 64'h100 + 64'(i), 3'b001);
        tick();
        clear_in();
        chk("rr0_src", wb_src, 0);
        chk("rr0_id", wb_inst_id, 6'h20);
        tick();
        chk("rr1_src", wb_src, 1);
        chk("rr1_id", wb_inst_id, 6'h21);
        tick();
        chk("rr2_src", wb_src, 2);
        chk("rr2_data", wb_data[0], 64'h102);
        tick();
        chk("rr3_src", wb_src, 3);
        chk("rr3_prn", wb_prn[0], 3);
        tick();
        chk("rr_done_valid", wb_valid, 0);

        // Single push on FU2
        drive(2, 6'h15, 6'd3, 64'hDEAD, 3'b001);
        tick();
        clear_in();
        chk("single_valid", wb_valid, 1);
        chk("single_src", wb_src, 2);
        chk("single_id", wb_inst_id, 6'h15);
        chk("single_data", wb_data[0], 64'hDEAD);
        chk("single_prn", wb_prn, {6'd0, 6'd0, 6'd3});
        chk("single_dv", wb_data_valid, 3'b001);
        tick();
        chk("single_after_valid", wb_valid, 0);
        chk("single_rr", dut.rr_ptr_q, 3);

        // Bring rr_ptr back to 0 via an FU3 grant
        drive(3, 6'h33, 6'd1, 64'h33, 3'b111);
        tick();
        clear_in();
        chk("fill_src", wb_src, 3);
        tick();
        chk("fill_rr", dut.rr_ptr_q, 0);

        // Grant lock: FU3 stalled, FU0 arrives, FU3 must stay granted
        wb_ready = 1'b0;
        drive(3, 6'h3A, 6'd7, 64'hA3, 3'b011);
        tick();
        clear_in();
        chk("lock_first_src", wb_src, 3);
        drive(0, 6'h0A, 6'd9, 64'hA0, 3'b100);
        tick();
        clear_in();
        chk("lock_hold_src", wb_src, 3);
        chk("lock_hold_id", wb_inst_id, 6'h3A);
        tick();
        chk("lock_hold2_src", wb_src, 3);
        chk("lock_hold2_data", wb_data[0], 64'hA3);
        wb_ready = 1'b1;
        tick();
        chk("lock_next_src", wb_src, 0);
        chk("lock_next_id", wb_inst_id, 6'h0A);
        chk("lock_next_dv", wb_data_valid, 3'b100);
        tick();
        chk("lock_done_valid", wb_valid, 0);

        // Backpressure: FU0 fills, third packet held off
        wb_ready = 1'b0;
        drive(0, 6'h01, 6'd1, 64'h1, 3'b001);
        tick();
        chk("bp_ready_after1", fu_out_ready[0], 1);
        drive(0, 6'h02, 6'd2, 64'h2, 3'b001);
        tick();
        chk("bp_ready_full", fu_out_ready[0], 0);
        chk("bp_head_id", wb_inst_id, 6'h01);
        drive(0, 6'h03, 6'd3, 64'h3, 3'b001);
        tick();
        chk("bp_still_full", fu_out_ready[0], 0);
        chk("bp_stable_id", wb_inst_id, 6'h01);
        chk("bp_stable_src", wb_src, 0);
        wb_ready = 1'b1;
        tick();
        chk("bp_drain2_id", wb_inst_id, 6'h02);
        chk("bp_drain2_ready", fu_out_ready[0], 1);
        tick();
        clear_in();
        chk("bp_drain3_id", wb_inst_id, 6'h03);
        tick();
        chk("bp_empty", wb_valid, 0);

        // Flush: 2 in FU1, 1 in FU2, FU0 pushes during the flush cycle
        wb_ready = 1'b0;
        drive(1, 6'h11, 6'd1, 64'h11, 3'b001);
        drive(2, 6'h12, 6'd2, 64'h12, 3'b001);
        tick();
        clear_in();
        drive(1, 6'h13, 6'd3, 64'h13, 3'b001);
        tick();
        clear_in();
        chk("fl_pre_src", wb_src, 1);
        chk("fl_pre_id", wb_inst_id, 6'h11);
        chk("fl_pre_ready", fu_out_ready, 4'b1101);
        flush = 1'b1;
        drive(0, 6'h37, 6'd5, 64'h77, 3'b001);
        tick();
        flush = 1'b0;
        clear_in();
        chk("fl_valid", wb_valid, 0);
        chk("fl_ready", fu_out_ready, 4'hF);
        chk("fl_src", wb_src, 0);
        chk("fl_id", wb_inst_id, 0);
        tick();
        chk("fl_discard", wb_valid, 0);

        // Asynchronous reset mid-stall
        drive(2, 6'h2B, 6'd4, 64'h2B, 3'b010);
        tick();
        clear_in();
        chk("ar_pre_valid", wb_valid, 1);
        chk("ar_pre_src", wb_src, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid", wb_valid, 0);
        chk("ar_ready", fu_out_ready, 0);
        chk("ar_src", wb_src, 0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_fresh_ready", fu_out_ready, 4'hF);
        chk("ar_fresh_valid", wb_valid, 0);
        wb_ready = 1'b1;
        drive(1, 6'h1C, 6'd6, 64'h1C, 3'b001);
        tick();
        clear_in();
        chk("ar_new_src", wb_src, 1);
        chk("ar_new_id", wb_inst_id, 6'h1C);
        tick();
        chk("ar_new_done", wb_valid, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
